// File: rtl/adder_tree_pkg.sv
// Shared constants and types for the adder-tree feeder.
// Optional statistics outputs are enabled with ADDER_TREE_FEEDER_STATS_EN.
package adder_tree_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int NUM_INPUTS    = 32;
    localparam int BEAT_LANES    = 4;
    localparam int TREE_LATENCY  = 5;
    localparam int SUM_WIDTH     = 16;
    localparam int RES_DEPTH     = 2;

    localparam int BEATS_PER_VEC = NUM_INPUTS / BEAT_LANES;
    localparam int IDX_W         = (BEATS_PER_VEC > 1) ? $clog2(BEATS_PER_VEC) : 1;
    localparam int BEAT_W        = BEAT_LANES * DATA_WIDTH;
    localparam int VEC_W         = NUM_INPUTS * DATA_WIDTH;
    localparam int CNT_W         = $clog2(RES_DEPTH + 1);
    // Wide enough for every in-flight launch plus a full FIFO.
    localparam int OUT_W         = $clog2(TREE_LATENCY + RES_DEPTH + 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

endpackage

// File: rtl/adder_tree_result_fifo.sv
// Small registered-head FIFO holding tree sums; its count feeds credit accounting.
module adder_tree_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok  = pop && (cnt_q != '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push && ((cnt_q != CNT_W'(DEPTH)) || pop_ok);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push_ok) begin
            mem_d[wr_q] = push_data;
            wr_d        = nxt(wr_q);
        end
        if (pop_ok) begin
            rd_d = nxt(rd_q);
        end
        cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid = (cnt_q != '0);
    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/adder_tree_feeder_8bit.sv
// Packs 4-lane beats into a 32-lane operand vector, launches it into a fixed
// latency adder tree under credit control, and queues returning sums.
// Define ADDER_TREE_FEEDER_STATS_EN to add stat_vectors / stat_stall outputs.
module adder_tree_feeder_8bit
    import adder_tree_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BEAT_W-1:0]    in_data,
    input  logic                 in_last,
    output logic [VEC_W-1:0]     tree_inp,
    output logic                 tree_launch,
    input  logic [SUM_WIDTH-1:0] tree_sum,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SUM_WIDTH-1:0] res_data
`ifdef ADDER_TREE_FEEDER_STATS_EN
    ,
    output logic [15:0]          stat_vectors,
    output logic [15:0]          stat_stall
`endif
);

    state_e                                 state_q, state_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic [BEATS_PER_VEC-1:0][BEAT_W-1:0]   hold_q, hold_d;
    logic [TREE_LATENCY-1:0]                lp_q, lp_d;
    logic [CNT_W-1:0]                       fifo_cnt;
    logic [OUT_W-1:0]                       outstanding;
    logic                                   accept, pop;

    assign in_ready    = reset && (state_q == FILL);
    assign accept      = in_valid && in_ready;
    // Credit check uses the pre-pop count: no same-cycle bypass.
    assign tree_launch = (state_q == FULL) && (outstanding < OUT_W'(RES_DEPTH));
    assign pop         = res_valid && res_ready;
    assign tree_inp    = hold_q;

    // Outstanding = launches still in the tree + sums waiting in the FIFO.
    always_comb begin
        outstanding = OUT_W'(fifo_cnt);
        for (int i = 0; i < TREE_LATENCY; i++) begin
            outstanding = outstanding + OUT_W'(lp_q[i]);
        end
    end

    // Fill/launch sequencing and holding-register updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    hold_d[idx_q] = in_data;
                    if (in_last || (idx_q == IDX_W'(BEATS_PER_VEC - 1))) begin
                        state_d = FULL;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FULL: begin
                // Clearing on launch makes a short vector's unwritten lanes zero.
                if (tree_launch) begin
                    state_d = FILL;
                    hold_d  = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Launch pipe mirrors the tree latency; its tail marks sum capture.
    always_comb begin
        lp_d = {lp_q[TREE_LATENCY-2:0], tree_launch};
    end

    // Feeder state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            idx_q   <= '0;
            hold_q  <= '0;
            lp_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            lp_q    <= lp_d;
        end
    end

    adder_tree_result_fifo #(
        .WIDTH (SUM_WIDTH),
        .DEPTH (RES_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (lp_q[TREE_LATENCY-1]),
        .push_data (tree_sum),
        .pop       (pop),
        .valid     (res_valid),
        .head      (res_data),
        .count     (fifo_cnt)
    );

`ifdef ADDER_TREE_FEEDER_STATS_EN
    logic [15:0] stat_vec_q, stat_vec_d, stat_stall_q, stat_stall_d;

    // Saturating launch and credit-stall counters.
    always_comb begin
        stat_vec_d   = stat_vec_q;
        stat_stall_d = stat_stall_q;
        if (tree_launch && (stat_vec_q != 16'hFFFF)) begin
            stat_vec_d = stat_vec_q + 16'd1;
        end
        if ((state_q == FULL) && !tree_launch && (stat_stall_q != 16'hFFFF)) begin
            stat_stall_d = stat_stall_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_vec_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_vec_q   <= stat_vec_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_vectors = stat_vec_q;
    assign stat_stall   = stat_stall_q;
`endif

endmodule
